udp_tx_arb: RTL

- Shares the single UDP transmit path of `mac` between two requesters: req0 is the ADC data stream from fifod, req1 is the status/command-reply source.
- Runs round-robin arbitration and drives the fs/fd start/done handshake toward `mac`.
- Pulls payload bytes from the granted requester's FIFO-style source.
- Checks length, enforces a timeout and guards against overrun.
- Sits between the fifod2mac/status sources and `mac`, in the gmii_txc domain.

---
 rtl/udp_tx_arb.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/udp_tx_arb.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// udp_tx_arb
//
// Shares the single UDP transmit path of the MAC between two requesters
// (req0 = ADC data stream, req1 = status / command-reply source). A
// round-robin arbiter picks an owner, the owner's length is latched and
// checked, the fs/fd start/done handshake toward the MAC is driven, and
// payload bytes are pulled from the owner's FIFO-style source one byte per
// MAC request. A cycle timeout and an overrun guard protect the transfer.
// All logic lives in the gmii_txc clock domain.
//
// Ports
//   clk_i            gmii_txc-domain clock
//   rst_i            synchronous active-high reset
//   fs_reqN_i        requester N start (level, held until fd_reqN_o seen)
//   fd_reqN_o        requester N done
//   reqN_len_i       requester N payload length in bytes
//   reqN_rxen_o      requester N byte pop
//   reqN_rxd_i       requester N byte, valid the cycle after reqN_rxen_o
//   fs_udp_tx_o      start toward the MAC
//   fd_udp_tx_i      done from the MAC, held until fs_udp_tx_o falls
//   udp_tx_len_o     latched length presented to the MAC
//   udp_tx_req_i     MAC requests one payload byte this cycle
//   udp_txen_o       udp_txd_o valid
//   udp_txd_o        payload byte
//   grant_o          one-hot owner, 00 when idle
//   err_o            one-cycle error pulse
//   err_code_o       0 none, 1 bad length, 2 timeout, 3 overrun
// -----------------------------------------------------------------------------
module udp_tx_arb #(
   parameter logic [11:0] LEN_MAX   = 12'd1472,
   parameter logic [19:0] TO_CYCLES = 20'd1000000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        fs_req0_i,
   output logic        fd_req0_o,
   input  logic [11:0] req0_len_i,
   output logic        req0_rxen_o,
   input  logic [7:0]  req0_rxd_i,
   input  logic        fs_req1_i,
   output logic        fd_req1_o,
   input  logic [11:0] req1_len_i,
   output logic        req1_rxen_o,
   input  logic [7:0]  req1_rxd_i,
   output logic        fs_udp_tx_o,
   input  logic        fd_udp_tx_i,
   output logic [11:0] udp_tx_len_o,
   input  logic        udp_tx_req_i,
   output logic        udp_txen_o,
   output logic [7:0]  udp_txd_o,
   output logic [1:0]  grant_o,
   output logic        err_o,
   output logic [1:0]  err_code_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_XFER  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_BADLEN  = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_OVERRUN = 2'd3;

   state_t      state_q, state_d;

   logic [1:0]  grant_q, grant_d;
   logic        last_q, last_d;          // 1 = requester 1 was granted last
   logic [11:0] len_q, len_d;
   logic [1:0]  err_code_q, err_code_d;
   logic        err_q, err_d;
   logic        fs_tx_q, fs_tx_d;
   logic [1:0]  fd_req_q, fd_req_d;
   logic        txen_q, txen_d;
   logic [11:0] byte_cnt_q, byte_cnt_d;
   logic [19:0] timer_q, timer_d;
   logic        ovr_q, ovr_d;            // sticky: MAC asked past the end

   logic        any_s;
   logic        pick_s;                  // requester that would win in IDLE
   logic        fs_own_s;
   logic [7:0]  rxd_own_s;
   logic        len_bad_s;
   logic        tmo_s;
   logic        req_ok_s;
   logic        pop_s;
   logic        ovr_hit_s;

   // Arbitration choice, owner muxes and transfer qualifiers.
   always_comb begin
      any_s = fs_req0_i | fs_req1_i;
      // On a tie the requester that did not own the path last time wins.
      if (fs_req0_i && fs_req1_i) begin
         pick_s = ~last_q;
      end else begin
         pick_s = fs_req1_i;
      end
      fs_own_s  = grant_q[1] ? fs_req1_i  : fs_req0_i;
      rxd_own_s = grant_q[1] ? req1_rxd_i : req0_rxd_i;
      len_bad_s = (len_q == 12'd0) || (len_q > LEN_MAX);
      tmo_s     = (timer_q >= (TO_CYCLES - 20'd1));
      // A request in the same cycle as fd is ignored: no pops after done.
      req_ok_s  = (state_q == S_XFER) && udp_tx_req_i && !fd_udp_tx_i;
      pop_s     = req_ok_s && (byte_cnt_q < len_q);
      ovr_hit_s = req_ok_s && !(byte_cnt_q < len_q);
   end

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (any_s) begin
               state_d = S_GRANT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GRANT: begin
            if (len_bad_s) begin
               state_d = S_DONE;
            end else begin
               state_d = S_XFER;
            end
         end
         S_XFER: begin
            if (fd_udp_tx_i || tmo_s) begin
               state_d = S_DONE;
            end else begin
               state_d = S_XFER;
            end
         end
         S_DONE: begin
            if (!fs_own_s && !fd_udp_tx_i) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM output / datapath next-state logic.
   always_comb begin
      grant_d    = grant_q;
      last_d     = last_q;
      len_d      = len_q;
      err_code_d = err_code_q;
      err_d      = 1'b0;
      fs_tx_d    = fs_tx_q;
      fd_req_d   = fd_req_q;
      txen_d     = pop_s;
      byte_cnt_d = byte_cnt_q;
      timer_d    = timer_q;
      ovr_d      = ovr_q;
      case (state_q)
         S_IDLE: begin
            if (any_s) begin
               grant_d    = pick_s ? 2'b10 : 2'b01;
               last_d     = pick_s;
               len_d      = pick_s ? req1_len_i : req0_len_i;
               err_code_d = ERR_NONE;
               byte_cnt_d = 12'd0;
               timer_d    = 20'd0;
               ovr_d      = 1'b0;
            end else begin
               grant_d    = grant_q;
            end
         end
         S_GRANT: begin
            // A bad length never reaches the MAC.
            if (len_bad_s) begin
               err_code_d = ERR_BADLEN;
               err_d      = 1'b1;
               fd_req_d   = grant_q;
            end else begin
               fs_tx_d    = 1'b1;
            end
         end
         S_XFER: begin
            timer_d = (timer_q != 20'hFFFFF) ? (timer_q + 20'd1) : timer_q;
            if (pop_s && (byte_cnt_q != 12'hFFF)) begin
               byte_cnt_d = byte_cnt_q + 12'd1;
            end else begin
               byte_cnt_d = byte_cnt_q;
            end
            if (ovr_hit_s) begin
               ovr_d = 1'b1;
            end else begin
               ovr_d = ovr_q;
            end
            // fd has priority over a timeout expiring in the same cycle.
            if (fd_udp_tx_i) begin
               fs_tx_d    = 1'b0;
               err_code_d = ovr_q ? ERR_OVERRUN : ERR_NONE;
               err_d      = ovr_q;
               fd_req_d   = grant_q;
            end else if (tmo_s) begin
               fs_tx_d    = 1'b0;
               err_code_d = ERR_TIMEOUT;
               err_d      = 1'b1;
               fd_req_d   = grant_q;
            end else begin
               fs_tx_d    = 1'b1;
            end
         end
         S_DONE: begin
            if (!fs_own_s && !fd_udp_tx_i) begin
               fd_req_d   = 2'b00;
               grant_d    = 2'b00;
               byte_cnt_d = 12'd0;
               timer_d    = 20'd0;
            end else begin
               fd_req_d   = fd_req_q;
            end
         end
         default: begin
            grant_d = 2'b00;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         grant_q    <= 2'b00;
         last_q     <= 1'b1;
         len_q      <= 12'd0;
         err_code_q <= ERR_NONE;
         err_q      <= 1'b0;
         fs_tx_q    <= 1'b0;
         fd_req_q   <= 2'b00;
         txen_q     <= 1'b0;
         byte_cnt_q <= 12'd0;
         timer_q    <= 20'd0;
         ovr_q      <= 1'b0;
      end else begin
         grant_q    <= grant_d;
         last_q     <= last_d;
         len_q      <= len_d;
         err_code_q <= err_code_d;
         err_q      <= err_d;
         fs_tx_q    <= fs_tx_d;
         fd_req_q   <= fd_req_d;
         txen_q     <= txen_d;
         byte_cnt_q <= byte_cnt_d;
         timer_q    <= timer_d;
         ovr_q      <= ovr_d;
      end
   end

   // The pop strobe is combinational so the source byte arrives exactly one
   // cycle later, when txen_q forwards it straight to the MAC.
   assign req0_rxen_o  = pop_s & grant_q[0];
   assign req1_rxen_o  = pop_s & grant_q[1];
   assign udp_txen_o   = txen_q;
   assign udp_txd_o    = txen_q ? rxd_own_s : 8'd0;
   assign fd_req0_o    = fd_req_q[0];
   assign fd_req1_o    = fd_req_q[1];
   assign fs_udp_tx_o  = fs_tx_q;
   assign udp_tx_len_o = len_q;
   assign grant_o      = grant_q;
   assign err_o        = err_q;
   assign err_code_o   = err_code_q;

endmodule
